// File: rtl/lcd_screen_sequencer_if.sv
// Host buffer writes, refresh request and transaction-layer handshake for lcd_screen_sequencer.
interface lcd_screen_sequencer_if;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       refresh;
  logic       set_dd_ram_addr_done;
  logic       send_data_done;
  logic       do_set_dd_ram_addr;
  logic [6:0] dd_ram_addr;
  logic       do_write_data;
  logic [7:0] data_to_write;
  logic       busy;
  logic       frame_done;
  logic       err;

  modport master (
    output buf_we, buf_addr, buf_wdata, refresh, set_dd_ram_addr_done, send_data_done,
    input  do_set_dd_ram_addr, dd_ram_addr, do_write_data, data_to_write, busy, frame_done, err
  );

  modport slave (
    input  buf_we, buf_addr, buf_wdata, refresh, set_dd_ram_addr_done, send_data_done,
    output do_set_dd_ram_addr, dd_ram_addr, do_write_data, data_to_write, busy, frame_done, err
  );
endinterface

// File: rtl/lcd_screen_sequencer.sv
// Replays a 2-line shadow character buffer to the LCD transaction layer on refresh,
// one request/done handshake per step, each step guarded by a watchdog.
module lcd_screen_sequencer #(
  parameter int COLS    = 16,
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input logic                   clk,
  input logic                   reset,
  lcd_screen_sequencer_if.slave bus
);

  localparam int NCHR  = 2 * COLS;
  localparam int IDX_W = $clog2(NCHR);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SET_ADDR  = 3'd1,
    S_WAIT_ADDR = 3'd2,
    S_WRITE_CHR = 3'd3,
    S_WAIT_CHR  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           r_state;
  logic [7:0]       r_buf [NCHR];
  logic [IDX_W-1:0] r_idx;
  logic             r_pending;
  logic [TO_W-1:0]  r_wd;
  logic             r_do_set;
  logic [6:0]       r_dd_addr;
  logic             r_do_wr;
  logic [7:0]       r_data;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_err;

  logic [IDX_W-1:0] w_idx_inc;
  logic             w_last_line1;
  logic             w_last;
  logic             w_expire;

  assign w_idx_inc    = r_idx + 1'b1;
  assign w_last_line1 = (r_idx == IDX_W'(COLS - 1));
  assign w_last       = (r_idx == IDX_W'(NCHR - 1));
  assign w_expire     = (r_wd == TO_W'(TIMEOUT - 1));

  // Host writes land at any time; a same-cycle read of that entry still sees the old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCHR; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else if (bus.buf_we) begin
      r_buf[bus.buf_addr] <= bus.buf_wdata;
    end
  end

  // Requests are registered on the edge entering their state so each pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_wd         <= '0;
      r_do_set     <= 1'b0;
      r_dd_addr    <= 7'h00;
      r_do_wr      <= 1'b0;
      r_data       <= 8'h00;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_do_set     <= 1'b0;
      r_do_wr      <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.refresh && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.refresh) begin
            r_state   <= S_SET_ADDR;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_do_set  <= 1'b1;
            r_dd_addr <= 7'h00;
          end
        end
        S_SET_ADDR: begin
          r_wd    <= '0;
          r_state <= S_WAIT_ADDR;
        end
        S_WAIT_ADDR: begin
          if (bus.set_dd_ram_addr_done) begin
            r_state <= S_WRITE_CHR;
            r_do_wr <= 1'b1;
            r_data  <= r_buf[r_idx];
          end else if (w_expire) begin
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_WRITE_CHR: begin
          r_wd    <= '0;
          r_state <= S_WAIT_CHR;
        end
        S_WAIT_CHR: begin
          if (bus.send_data_done) begin
            r_idx <= w_idx_inc;
            if (w_last) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end else if (w_last_line1) begin
              r_state   <= S_SET_ADDR;
              r_do_set  <= 1'b1;
              r_dd_addr <= 7'h40;
            end else begin
              r_state <= S_WRITE_CHR;
              r_do_wr <= 1'b1;
              r_data  <= r_buf[w_idx_inc];
            end
          end else if (w_expire) begin
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DONE: begin
          // A refresh landing in this very cycle counts as pending too.
          if (r_pending || bus.refresh) begin
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_state   <= S_SET_ADDR;
            r_do_set  <= 1'b1;
            r_dd_addr <= 7'h00;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.do_set_dd_ram_addr = r_do_set;
  assign bus.dd_ram_addr        = r_dd_addr;
  assign bus.do_write_data      = r_do_wr;
  assign bus.data_to_write      = r_data;
  assign bus.busy               = r_busy;
  assign bus.frame_done         = r_frame_done;
  assign bus.err                = r_err;

endmodule

// File: tb/tb_lcd_screen_sequencer.sv
// Directed self-checking bench for lcd_screen_sequencer (TIMEOUT shortened to 50 cycles).
module tb_lcd_screen_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   fd_cnt;
  logic [7:0] model [32];

  lcd_screen_sequencer_if bus ();

  lcd_screen_sequencer #(
    .COLS    (16),
    .TIMEOUT (50),
    .TO_W    (6)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial fd_cnt = 0;
  always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.buf_we    = 1'b1;
    bus.buf_addr  = a;
    bus.buf_wdata = d;
    tick();
    bus.buf_we = 1'b0;
    model[a] = d;
  endtask

  task automatic start_frame(input string tag, input bit w, input logic [4:0] a, input logic [7:0] d);
    bus.refresh = 1'b1;
    if (w) begin
      bus.buf_we    = 1'b1;
      bus.buf_addr  = a;
      bus.buf_wdata = d;
      model[a] = d;
    end
    tick();
    bus.refresh = 1'b0;
    bus.buf_we  = 1'b0;
    check($sformatf("%s_first_req", tag), {bus.do_set_dd_ram_addr, bus.dd_ram_addr, bus.busy, bus.err},
          {1'b1, 7'h00, 1'b1, 1'b0});
  endtask

  // Waits for one request, then answers it with its done pulse dly cycles later.
  task automatic serve(input int dly, input bit pulse_ref, input bit stray, input bit w,
                       input logic [4:0] wa, input logic [7:0] wd, input bit hold,
                       output logic [8:0] obs, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.do_set_dd_ram_addr === 1'b1 || bus.do_write_data === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    obs = (bus.do_set_dd_ram_addr === 1'b1) ? {1'b1, 1'b0, bus.dd_ram_addr} : {1'b0, bus.data_to_write};
    if (!ok || hold) return;
    bus.refresh = pulse_ref;
    if (w) begin
      bus.buf_we    = 1'b1;
      bus.buf_addr  = wa;
      bus.buf_wdata = wd;
    end
    for (int d = 1; d < dly; d++) begin
      tick();
      bus.refresh = 1'b0;
      bus.buf_we  = 1'b0;
      bus.send_data_done       = stray && (d == 1) && obs[8];
      bus.set_dd_ram_addr_done = stray && (d == 1) && !obs[8];
    end
    tick();
    bus.refresh = 1'b0;
    bus.buf_we  = 1'b0;
    bus.set_dd_ram_addr_done = obs[8];
    bus.send_data_done       = !obs[8];
    tick();
    bus.set_dd_ram_addr_done = 1'b0;
    bus.send_data_done       = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int dmin, input int dmax, input int ref_k,
                           input int stray_k, input int wr_k, input int stop_k);
    logic [7:0] snap [32];
    logic [8:0] obs;
    logic [8:0] exp;
    bit ok;
    int d;
    int ci;
    int start;
    int sumd;
    snap  = model;
    sumd  = 0;
    start = cyc;
    for (int k = 0; k < 34; k++) begin
      ci = (k < 17) ? k - 1 : k - 2;
      if (k == 0) exp = 9'h100;
      else if (k == 17) exp = 9'h140;
      else exp = {1'b0, snap[ci]};
      d = $urandom_range(dmax, dmin);
      if (k == stray_k && d < 2) d = 2;
      if (k == 0) start = cyc;
      serve(d, (ref_k >= 0) && (k == ref_k || k == ref_k + 2 || k == ref_k + 4), k == stray_k,
            k == wr_k, 5'(ci), 8'hA5 ^ 8'(k), k == stop_k, obs, ok);
      if (k == wr_k) model[ci] = 8'hA5 ^ 8'(k);
      check($sformatf("%s_step%0d", tag, k), {ok, obs}, {1'b1, exp});
      if (!ok || k == stop_k) return;
      sumd += d + 1;
    end
    check($sformatf("%s_frame_done", tag), {bus.frame_done, bus.busy}, 2'b11);
    check($sformatf("%s_frame_len", tag), cyc - start, sumd);
  endtask

  initial begin
    int fd0;
    logic seen;
    string s1;
    string s2;
    checks   = 0;
    failures = 0;
    reset = 1'b0;
    bus.buf_we = 1'b0; bus.buf_addr = 5'd0; bus.buf_wdata = 8'h00; bus.refresh = 1'b0;
    bus.set_dd_ram_addr_done = 1'b0; bus.send_data_done = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h20;

    // Reset defaults
    tick(); tick();
    check("reset_outs", {bus.do_set_dd_ram_addr, bus.dd_ram_addr, bus.do_write_data, bus.data_to_write,
          bus.busy, bus.frame_done, bus.err}, 32'h0);
    reset = 1'b1;
    tick();
    fd0 = fd_cnt;
    start_frame("f1", 1'b0, 5'd0, 8'h00);
    run_frame("f1", 1, 1, -1, -1, -1, -1);
    tick();
    check("f1_idle", {bus.busy, bus.frame_done, bus.err}, 3'b000);
    check("f1_fd_count", fd_cnt - fd0, 1);

    // Buffer ordering with random ack latency
    s1 = "HELLO";
    s2 = "WORLD";
    for (int i = 0; i < 5; i++) wr(5'(i), s1[i]);
    for (int i = 0; i < 5; i++) wr(5'(16 + i), s2[i]);
    start_frame("f2", 1'b0, 5'd0, 8'h00);
    run_frame("f2", 1, 10, -1, -1, -1, -1);
    tick();
    check("f2_idle", bus.busy, 1'b0);

    // Pending collapse; refresh with same-cycle write reads the new value
    fd0 = fd_cnt;
    start_frame("f3", 1'b1, 5'd31, 8'h5A);
    run_frame("f3a", 1, 2, 4, -1, -1, -1);
    tick();
    check("f3_restart", {bus.do_set_dd_ram_addr, bus.busy, bus.dd_ram_addr}, {1'b1, 1'b1, 7'h00});
    run_frame("f3b", 1, 1, -1, -1, -1, -1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | bus.do_set_dd_ram_addr | bus.do_write_data | bus.busy;
    end
    check("f3_no_third", seen, 1'b0);
    check("f3_fd_count", fd_cnt - fd0, 2);

    // Stray done in WAIT_ADDR; same-cycle write to the entry being sent
    start_frame("f4", 1'b0, 5'd0, 8'h00);
    run_frame("f4", 1, 3, -1, 0, 3, -1);
    tick();
    start_frame("f5", 1'b0, 5'd0, 8'h00);
    run_frame("f5", 1, 1, -1, -1, -1, -1);
    tick();

    // Watchdog expiry on the 5th character
    fd0 = fd_cnt;
    start_frame("to", 1'b0, 5'd0, 8'h00);
    run_frame("to", 1, 1, -1, -1, -1, 5);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen = seen | bus.do_set_dd_ram_addr | bus.do_write_data;
    end
    check("to_before", {bus.err, bus.busy}, 2'b01);
    tick();
    check("to_flag", {bus.err, bus.busy, bus.frame_done}, 3'b100);
    check("to_no_req", seen, 1'b0);
    check("to_fd_count", fd_cnt - fd0, 0);
    start_frame("to2", 1'b0, 5'd0, 8'h00);
    run_frame("to2", 1, 1, -1, -1, -1, -1);
    tick();

    // Reset during the 10th WAIT_CHR
    start_frame("rm", 1'b0, 5'd0, 8'h00);
    run_frame("rm", 1, 1, -1, -1, -1, 10);
    tick();
    reset = 1'b0;
    tick();
    check("rm_outs", {bus.do_set_dd_ram_addr, bus.dd_ram_addr, bus.do_write_data, bus.data_to_write,
          bus.busy, bus.frame_done, bus.err}, 32'h0);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | bus.do_set_dd_ram_addr | bus.do_write_data | bus.busy;
    end
    check("rm_quiet", seen, 1'b0);
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    start_frame("rm2", 1'b0, 5'd0, 8'h00);
    run_frame("rm2", 1, 1, -1, -1, -1, -1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
